eth_rx: RTL and testbench

Receive-side Ethernet MAC datapath, the counterpart of eth_tx inside eth_core.
- Accepts a GMII-style byte stream (rx_dv/rx_er/rxd) synchronous to ACLK.
- Strips preamble/SFD, checks CRC-32 and frame length, removes the FCS and packs payload bytes into 32-bit words.
- Store-and-forward FIFO: only good frames become visible on the stream output; bad frames are rolled back and never emitted.
- A per-frame status pulse feeds the AXI register side.

---
 rtl/eth_rx_if.sv | 13 +
 rtl/eth_rx.sv | 197 +++++++++++++++++++
 tb/tb_eth_rx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_if.sv
// eth_rx_if: GMII receive byte stream in, AXI-Stream payload words out
interface eth_rx_if;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rxd;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    modport master (output rx_dv, rx_er, rxd, m_tready, input m_tdata, m_tkeep, m_tlast, m_tvalid);
    modport slave (input rx_dv, rx_er, rxd, m_tready, output m_tdata, m_tkeep, m_tlast, m_tvalid);
endinterface

// File: rtl/eth_rx.sv
// eth_rx: receive MAC datapath, preamble strip, CRC/length check, store-and-forward FIFO to 32-bit stream
module eth_rx #(
    parameter int FIFO_AW   = 9,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        ACLK,
    input  logic        ARESET,
    eth_rx_if.slave     bus,
    output logic        stat_valid,
    output logic [10:0] stat_len,
    output logic [3:0]  stat_err,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_drop
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
    typedef logic [FIFO_AW:0] ptr_t;

    state_t      state_q, state_d;
    logic        dv_q;
    logic [31:0] crc_q, crc_d, dl_q, dl_d, last_q, last_d;
    logic [23:0] asm_q, asm_d;
    logic [1:0]  lane_q, lane_d;
    logic [10:0] cnt_q, cnt_d, slen_q, slen_d;
    logic        er_q, er_d, ovf_q, ovf_d, pend_q, pend_d;
    logic [3:0]  serr_q, serr_d, keep;
    logic [15:0] ok_q, ok_d, drop_q, drop_d;
    ptr_t        wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, wa;
    logic        we, full, stop, ren, pop, p_vld_q, p_vld_d, o_vld_q, o_vld_d;
    logic [36:0] wd, rdat_q, o_q, o_d;
    logic [36:0] mem [DEPTH];

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB8_8320 : r >> 1;
        return r;
    endfunction

    assign full = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) && (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    assign keep = lane_q == 2'd1 ? 4'b0001 : lane_q == 2'd2 ? 4'b0011 : 4'b0111;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        dl_d    = dl_q;
        asm_d   = asm_q;
        lane_d  = lane_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        er_d    = er_q;
        ovf_d   = ovf_q;
        wr_d    = wr_q;
        cm_d    = cm_q;
        pend_d  = 1'b0;
        slen_d  = slen_q;
        serr_d  = serr_q;
        ok_d    = ok_q;
        drop_d  = drop_q;
        we      = 1'b0;
        wa      = wr_q;
        wd      = '0;
        stop    = ovf_q || cnt_q > 11'(MAX_FRAME);
        case (state_q)
            IDLE: if (bus.rx_dv) state_d = (!dv_q && bus.rxd == 8'h55) ? PRE : DROP;
            PRE: begin
                if (!bus.rx_dv) state_d = IDLE;
                else if (bus.rxd == 8'hD5) begin
                    state_d = DATA;
                    crc_d   = '1;
                    cnt_d   = '0;
                    lane_d  = '0;
                    er_d    = 1'b0;
                    ovf_d   = 1'b0;
                end else if (bus.rxd != 8'h55) state_d = DROP;
            end
            DATA: begin
                if (bus.rx_dv) begin
                    crc_d = crc_byte(crc_q, bus.rxd);
                    dl_d  = {bus.rxd, dl_q[31:8]};
                    cnt_d = cnt_q + 11'(cnt_q != 11'd2047);
                    er_d  = er_q | bus.rx_er;
                    // the 4-byte delay line holds back the FCS so it never reaches the FIFO
                    if (cnt_q >= 11'd4) begin
                        lane_d = lane_q + 2'd1;
                        if (lane_q != 2'd3) asm_d[{lane_q, 3'b000} +: 8] = dl_q[7:0];
                        else begin
                            last_d = {dl_q[7:0], asm_q};
                            if (!stop && full) ovf_d = 1'b1;
                            else if (!stop) begin
                                we   = 1'b1;
                                wd   = {1'b0, 4'hF, dl_q[7:0], asm_q};
                                wr_d = wr_q + ptr_t'(1);
                            end
                        end
                    end
                end else begin
                    state_d = IDLE;
                    // an empty remainder re-marks the last full word of this frame as tlast
                    if (!stop && lane_q != 2'd0) begin
                        if (full) ovf_d = 1'b1;
                        else begin
                            we   = 1'b1;
                            wd   = {1'b1, keep, 8'h00, asm_q & {{8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}}};
                            wr_d = wr_q + ptr_t'(1);
                        end
                    end else if (!stop && wr_q != cm_q) begin
                        we = 1'b1;
                        wa = wr_q - ptr_t'(1);
                        wd = {1'b1, 4'hF, last_q};
                    end
                    pend_d = 1'b1;
                    serr_d = {ovf_d, er_q, cnt_q < 11'(MIN_FRAME) || cnt_q > 11'(MAX_FRAME), crc_q != 32'hDEBB_20E3};
                    slen_d = cnt_q < 11'd4 ? 11'd0 : cnt_q - 11'd4;
                end
            end
            DROP: if (!bus.rx_dv) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (pend_q && serr_q == 4'd0) begin
            cm_d = wr_q;
            ok_d = ok_q + 16'(ok_q != 16'hFFFF);
        end else if (pend_q) begin
            wr_d   = cm_q;
            drop_d = drop_q + 16'(drop_q != 16'hFFFF);
        end
    end

    assign pop     = p_vld_q && (!o_vld_q || bus.m_tready);
    assign ren     = (rd_q != cm_q) && (!p_vld_q || pop);
    assign rd_d    = rd_q + ptr_t'(ren);
    assign p_vld_d = ren || (p_vld_q && !pop);
    assign o_vld_d = pop || (o_vld_q && !bus.m_tready);
    assign o_d     = pop ? rdat_q : o_q;

    always_ff @(posedge ACLK) begin
        if (we) mem[wa[FIFO_AW-1:0]] <= wd;
        if (ren) rdat_q <= mem[rd_q[FIFO_AW-1:0]];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
            dv_q    <= 1'b1;
            crc_q   <= '1;
            dl_q    <= '0;
            asm_q   <= '0;
            lane_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            er_q    <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            cm_q    <= '0;
            rd_q    <= '0;
            pend_q  <= 1'b0;
            slen_q  <= '0;
            serr_q  <= '0;
            ok_q    <= '0;
            drop_q  <= '0;
            p_vld_q <= 1'b0;
            o_vld_q <= 1'b0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            dv_q    <= bus.rx_dv;
            crc_q   <= crc_d;
            dl_q    <= dl_d;
            asm_q   <= asm_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            er_q    <= er_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            cm_q    <= cm_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
            slen_q  <= slen_d;
            serr_q  <= serr_d;
            ok_q    <= ok_d;
            drop_q  <= drop_d;
            p_vld_q <= p_vld_d;
            o_vld_q <= o_vld_d;
            o_q     <= o_d;
        end
    end

    assign bus.m_tvalid = o_vld_q;
    assign {bus.m_tlast, bus.m_tkeep, bus.m_tdata} = o_q;
    assign stat_valid = pend_q;
    assign stat_len   = slen_q;
    assign stat_err   = serr_q;
    assign cnt_ok     = ok_q;
    assign cnt_drop   = drop_q;
endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: directed frames through eth_rx with hand-derived expected words, status and counters
module tb_eth_rx;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        stat_valid;
    logic [10:0] stat_len;
    logic [3:0]  stat_err;
    logic [15:0] cnt_ok, cnt_drop;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        seen;
    logic [31:0] held;

    eth_rx_if bus();

    eth_rx #(.FIFO_AW(9), .MIN_FRAME(64), .MAX_FRAME(1518)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .stat_valid(stat_valid), .stat_len(stat_len),
        .stat_err(stat_err), .cnt_ok(cnt_ok), .cnt_drop(cnt_drop)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB8_8320 : r >> 1;
        return r;
    endfunction

    // payload byte i is (i + seed); FCS appended LSB first; byte 'flip' is corrupted after the FCS is computed
    task automatic send(input int n, input int seed, input int flip);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) c = crc_upd(c, 8'(i + seed));
        c = ~c;
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            bus.rx_dv = 1'b1;
            bus.rxd   = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < n + 4; i++) begin
            @(negedge ACLK);
            b = (i < n) ? 8'(i + seed) : c[8*(i-n) +: 8];
            bus.rxd = (i == flip) ? b ^ 8'h01 : b;
        end
        @(negedge ACLK);
        bus.rx_dv = 1'b0;
        bus.rxd   = 8'h00;
    endtask

    task automatic wait_stat(input logic [10:0] len, input logic [3:0] err);
        int t = 0;
        while (!stat_valid && t < 40) begin
            @(negedge ACLK);
            t++;
        end
        chk("stat_valid", stat_valid, 1'b1);
        chk("stat_len", stat_len, len);
        chk("stat_err", stat_err, err);
        @(negedge ACLK);
    endtask

    task automatic collect(input int n, input int seed);
        int          nw, t;
        logic [31:0] ed;
        logic [3:0]  ek;
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            t = 0;
            while (!bus.m_tvalid && t < 200) begin
                @(negedge ACLK);
                t++;
            end
            chk("word_valid", bus.m_tvalid, 1'b1);
            if (!bus.m_tvalid) return;
            ed = '0;
            ek = '0;
            for (int l = 0; l < 4; l++) if (4*w + l < n) begin
                ed[8*l +: 8] = 8'(4*w + l + seed);
                ek[l] = 1'b1;
            end
            chk("tdata", bus.m_tdata, ed);
            chk("tkeep", bus.m_tkeep, ek);
            chk("tlast", bus.m_tlast, w == nw - 1);
            @(negedge ACLK);
        end
    endtask

    task automatic quiet(input int cycles);
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge ACLK);
            if (bus.m_tvalid) seen = 1'b1;
        end
        chk("no_output", seen, 1'b0);
    endtask

    initial begin
        ARESET = 1'b1;
        bus.rx_dv = 1'b0;
        bus.rx_er = 1'b0;
        bus.rxd = 8'h00;
        bus.m_tready = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("rst_stream", {bus.m_tvalid, bus.m_tlast, bus.m_tkeep, bus.m_tdata}, 0);
        chk("rst_stat", {stat_valid, stat_len, stat_err}, 0);
        chk("rst_cnt", {cnt_ok, cnt_drop}, 0);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);

        send(60, 0, -1);
        wait_stat(60, 4'b0000);
        collect(60, 0);
        chk("t1_cnt_ok", cnt_ok, 1);
        chk("t1_cnt_drop", cnt_drop, 0);

        send(60, 0, 10);
        wait_stat(60, 4'b0001);
        quiet(12);
        chk("t2_cnt_drop", cnt_drop, 1);
        chk("t2_cnt_ok", cnt_ok, 1);

        send(61, 0, -1);
        wait_stat(61, 4'b0000);
        collect(61, 0);
        chk("t3_cnt_ok", cnt_ok, 2);

        send(16, 8'h20, -1);
        wait_stat(16, 4'b0010);
        quiet(12);
        send(1515, 8'h30, -1);
        wait_stat(1515, 4'b0010);
        quiet(12);
        send(63, 8'h90, -1);
        wait_stat(63, 4'b0000);
        collect(63, 8'h90);
        chk("t4_cnt_ok", cnt_ok, 3);
        chk("t4_cnt_drop", cnt_drop, 3);

        bus.m_tready = 1'b0;
        for (int f = 0; f < 34; f++) begin
            send(60, f, -1);
            wait_stat(60, 4'b0000);
        end
        send(60, 8'h80, -1);
        wait_stat(60, 4'b1000);
        chk("t5_cnt_ok", cnt_ok, 37);
        chk("t5_cnt_drop", cnt_drop, 4);
        held = bus.m_tdata;
        repeat (5) @(negedge ACLK);
        chk("t5_hold_valid", bus.m_tvalid, 1'b1);
        chk("t5_hold_data", bus.m_tdata, 32'h0302_0100);
        chk("t5_hold_stable", bus.m_tdata ^ held, 0);
        bus.m_tready = 1'b1;
        for (int f = 0; f < 34; f++) collect(60, f);
        quiet(12);

        send(60, 0, -1);
        repeat (3) @(negedge ACLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            bus.rx_dv = 1'b1;
            bus.rxd = 8'(i + 3);
        end
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("t6_rst_stream", {bus.m_tvalid, bus.m_tlast, bus.m_tkeep, bus.m_tdata}, 0);
        chk("t6_rst_stat", {stat_valid, stat_len, stat_err}, 0);
        chk("t6_rst_cnt", {cnt_ok, cnt_drop}, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        bus.rxd = 8'h55;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge ACLK);
            bus.rxd = (i < 6) ? 8'h55 : (i == 6) ? 8'hD5 : 8'(i);
            if (stat_valid || bus.m_tvalid) seen = 1'b1;
        end
        @(negedge ACLK);
        bus.rx_dv = 1'b0;
        repeat (15) begin
            @(negedge ACLK);
            if (stat_valid || bus.m_tvalid) seen = 1'b1;
        end
        chk("t6_drop_silent", seen, 1'b0);
        send(64, 8'h40, -1);
        wait_stat(64, 4'b0000);
        collect(64, 8'h40);
        chk("t6_cnt_ok", cnt_ok, 1);
        chk("t6_cnt_drop", cnt_drop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
